// File: rtl/student_audio_out_stage.sv
// student_audio_out_stage
//   Conditions the parallel FIR output before it reaches the IIS handler.
//   The stage applies an unsigned fixed-point gain with rounding and
//   saturation, buffers the result in a small FIFO, and releases one sample
//   per LR frame on each falling edge of the codec LR clock. FIFO underrun
//   and overflow events are reported as sticky flags and saturating counts.
//
// Ports
//   clk_i            system clock
//   rst_ni           asynchronous active-low reset
//   valid_strobe_in  one-cycle pulse, sample_in valid
//   sample_in        signed FIR output sample (IN_W)
//   gain_i           unsigned gain, value / 2^GAIN_FRAC (GAIN_W)
//   lrclk_i          codec LR clock, synchronous to clk_i
//   clear_i          synchronous clear of counters and sticky flags
//   sample_out       signed sample to IIS handler (OUT_W)
//   valid_strobe_out one-cycle pulse, one per LR frame
//   fill_o           FIFO occupancy
//   underrun_o       sticky: pop while FIFO empty
//   overflow_o       sticky: write dropped because FIFO full
//   underrun_cnt_o   saturating underrun count (CNT_W)
//   overflow_cnt_o   saturating overflow count (CNT_W)
module student_audio_out_stage #(
  parameter int IN_W      = 24,
  parameter int OUT_W     = 24,
  parameter int GAIN_W    = 8,
  parameter int GAIN_FRAC = 6,
  parameter int DEPTH     = 4,
  parameter int CNT_W     = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     valid_strobe_in,
  input  logic [IN_W-1:0]          sample_in,
  input  logic [GAIN_W-1:0]        gain_i,
  input  logic                     lrclk_i,
  input  logic                     clear_i,
  output logic [OUT_W-1:0]         sample_out,
  output logic                     valid_strobe_out,
  output logic [$clog2(DEPTH):0]   fill_o,
  output logic                     underrun_o,
  output logic                     overflow_o,
  output logic [CNT_W-1:0]         underrun_cnt_o,
  output logic [CNT_W-1:0]         overflow_cnt_o
);

  localparam int PROD_W = IN_W + GAIN_W + 1;
  localparam int AW     = $clog2(DEPTH);
  localparam int PW     = AW + 1;
  localparam logic [PROD_W-1:0] RND = {{(PROD_W-1){1'b0}}, 1'b1} << (GAIN_FRAC - 1);

  // Stage 1: full-precision product
  logic signed [PROD_W-1:0] w_prod;
  logic signed [PROD_W-1:0] r_prod;
  logic                     r_v1;

  assign w_prod = $signed(sample_in) * $signed({1'b0, gain_i});

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_v1   <= 1'b0;
      r_prod <= '0;
    end else begin
      r_v1 <= valid_strobe_in;
      if (valid_strobe_in) r_prod <= w_prod;
    end
  end

  // Stage 2: round half toward +inf, arithmetic shift, saturate
  logic signed [PROD_W-1:0] w_rnd;
  logic signed [PROD_W-1:0] w_shift;
  logic signed [PROD_W-1:0] w_max;
  logic signed [PROD_W-1:0] w_min;
  logic        [OUT_W-1:0]  w_sat;
  logic        [OUT_W-1:0]  r_s2;
  logic                     r_v2;

  assign w_rnd   = r_prod + $signed(RND);
  assign w_shift = w_rnd >>> GAIN_FRAC;
  assign w_max   = {{(PROD_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  assign w_min   = {{(PROD_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  always_comb begin
    w_sat = w_shift[OUT_W-1:0];
    if (w_shift > w_max)      w_sat = {1'b0, {(OUT_W-1){1'b1}}};
    else if (w_shift < w_min) w_sat = {1'b1, {(OUT_W-1){1'b0}}};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_v2 <= 1'b0;
      r_s2 <= '0;
    end else begin
      r_v2 <= r_v1;
      if (r_v1) r_s2 <= w_sat;
    end
  end

  // FIFO and frame release
  logic [OUT_W-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr;
  logic [PW-1:0]    r_rd;
  logic             r_lrq;
  logic             w_empty;
  logic             w_full;
  logic             w_fall;
  logic             w_pop;
  logic             w_push;
  logic             w_unf_ev;
  logic             w_ovf_ev;

  assign w_empty  = (r_wr == r_rd);
  assign w_full   = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign w_fall   = r_lrq & ~lrclk_i;
  assign w_pop    = w_fall & ~w_empty;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  // When full, write and read share an index; the read sees the old word.
  assign w_push   = r_v2 & (~w_full | w_pop);
  assign w_unf_ev = w_fall & w_empty;
  assign w_ovf_ev = r_v2 & w_full & ~w_pop;

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr[AW-1:0]] <= r_s2;
  end

  logic [OUT_W-1:0] r_out;
  logic             r_vout;
  logic             r_unf;
  logic             r_ovf;
  logic [CNT_W-1:0] r_ucnt;
  logic [CNT_W-1:0] r_ocnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_lrq  <= 1'b0;
      r_wr   <= '0;
      r_rd   <= '0;
      r_out  <= '0;
      r_vout <= 1'b0;
      r_unf  <= 1'b0;
      r_ovf  <= 1'b0;
      r_ucnt <= '0;
      r_ocnt <= '0;
    end else begin
      r_lrq  <= lrclk_i;
      r_wr   <= r_wr + PW'(w_push);
      r_rd   <= r_rd + PW'(w_pop);
      r_vout <= w_fall;
      if (w_pop) r_out <= r_mem[r_rd[AW-1:0]];
      if (clear_i) begin
        r_unf  <= 1'b0;
        r_ovf  <= 1'b0;
        r_ucnt <= '0;
        r_ocnt <= '0;
      end else begin
        if (w_unf_ev) begin
          r_unf <= 1'b1;
          if (r_ucnt != '1) r_ucnt <= r_ucnt + CNT_W'(1);
        end
        if (w_ovf_ev) begin
          r_ovf <= 1'b1;
          if (r_ocnt != '1) r_ocnt <= r_ocnt + CNT_W'(1);
        end
      end
    end
  end

  assign sample_out       = r_out;
  assign valid_strobe_out = r_vout;
  assign fill_o           = r_wr - r_rd;
  assign underrun_o       = r_unf;
  assign overflow_o       = r_ovf;
  assign underrun_cnt_o   = r_ucnt;
  assign overflow_cnt_o   = r_ocnt;

endmodule
